// File: rtl/conv_frame_loader.sv
//==============================================================================
// Module   : conv_frame_loader
// Brief    : Byte-serial loader that assembles a 3x3 FILTER word and a 4x4
//            DATA word from a valid/ready pixel stream, and presents them to
//            the convolution core with a frame_valid/frame_ready handshake.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module conv_frame_loader #(
  parameter int PIX_W  = 8,
  parameter int FILT_N = 9,
  parameter int DATA_N = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      reuse_filter,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PIX_W-1:0]          in_byte,
  output logic [FILT_N*PIX_W-1:0]   FILTER,
  output logic [DATA_N*PIX_W-1:0]   DATA,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [1:0]                state
);

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_F = 2'd1,
    S_LOAD_D = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [FILT_N*PIX_W-1:0]   filter_q;
  logic [DATA_N*PIX_W-1:0]   data_q;
  logic                      frame_valid_q;
  logic                      accept;

  // Ready only while loading; abort masks ready so an aborted beat is never taken.
  assign in_ready = ((state_q == S_LOAD_F) || (state_q == S_LOAD_D)) && !abort;
  assign accept   = in_ready && in_valid;

  assign FILTER      = filter_q;
  assign DATA        = data_q;
  assign frame_valid = frame_valid_q;
  assign state       = state_q;

  // Frame-load FSM: owns the lane counter, the assembled words and frame_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      filter_q      <= '0;
      data_q        <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            state_q <= reuse_filter ? S_LOAD_D : S_LOAD_F;
          end
        end

        S_LOAD_F: begin
          if (abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (accept) begin
            for (int k = 0; k < FILT_N; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                filter_q[k*PIX_W +: PIX_W] <= in_byte;
              end
            end
            if (cnt_q == CNT_W'(FILT_N-1)) begin
              state_q <= S_LOAD_D;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        S_LOAD_D: begin
          if (abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (accept) begin
            for (int k = 0; k < DATA_N; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                data_q[k*PIX_W +: PIX_W] <= in_byte;
              end
            end
            if (cnt_q == CNT_W'(DATA_N-1)) begin
              // Counter parks at zero so it never runs past the last lane.
              state_q       <= S_HOLD;
              cnt_q         <= '0;
              frame_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        S_HOLD: begin
          // A held frame cannot be aborted; only the consumer releases it.
          if (frame_ready) begin
            state_q       <= S_IDLE;
            frame_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_loader.sv
//==============================================================================
// Module   : tb_conv_frame_loader
// Brief    : Directed + randomized bench for conv_frame_loader with a
//            byte-array reference model of the FILTER and DATA words.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_conv_frame_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         reuse_filter = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_byte = 8'h00;
  logic [71:0]  FILTER;
  logic [127:0] DATA;
  logic         frame_valid;
  logic         frame_ready = 1'b0;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;

  // Reference model: the coefficient/pixel bytes currently held by the loader.
  logic [7:0] mf [9];
  logic [7:0] md [16];
  // Bytes for the next frame to stream.
  logic [7:0] nf [9];
  logic [7:0] nd [16];

  conv_frame_loader #(.PIX_W(8), .FILT_N(9), .DATA_N(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .reuse_filter (reuse_filter),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .FILTER       (FILTER),
    .DATA         (DATA),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .state        (state)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] exp_filter();
    logic [127:0] w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = mf[k];
    return w;
  endfunction

  function automatic logic [127:0] exp_data();
    logic [127:0] w = '0;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = md[k];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // gap_mode: 0 = back-to-back, 1 = alternate valid/idle, 2 = random idle gaps
  function automatic int pick_gap(input int gap_mode);
    if (gap_mode == 1) return 1;
    if (gap_mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  task automatic randomize_frame();
    for (int k = 0; k < 9; k++)  nf[k] = 8'($urandom);
    for (int k = 0; k < 16; k++) nd[k] = 8'($urandom);
  endtask

  task automatic load_frame(input string tag, input bit reuse, input int gap_mode,
                            input bit start_in_data);
    start        = 1'b1;
    reuse_filter = reuse;
    tick();
    start        = 1'b0;
    reuse_filter = 1'b0;
    chk({tag, "_enter"}, 128'(state), reuse ? 128'd2 : 128'd1);
    if (!reuse) begin
      for (int k = 0; k < 9; k++) begin
        send_byte(nf[k], pick_gap(gap_mode));
        mf[k] = nf[k];
      end
      chk({tag, "_to_load_d"}, 128'(state), 128'd2);
    end
    for (int k = 0; k < 16; k++) begin
      start = start_in_data;
      send_byte(nd[k], pick_gap(gap_mode));
      md[k] = nd[k];
      if (k < 15) chk({tag, "_no_early_fv"}, 128'(frame_valid), 128'd0);
    end
    start = 1'b0;
    chk({tag, "_hold"},     128'(state),       128'd3);
    chk({tag, "_fv"},       128'(frame_valid), 128'd1);
    chk({tag, "_rdy_hold"}, 128'(in_ready),    128'd0);
    chk({tag, "_filter"},   128'(FILTER),      exp_filter());
    chk({tag, "_data"},     DATA,              exp_data());
  endtask

  task automatic handshake(input string tag);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk({tag, "_idle"},     128'(state),       128'd0);
    chk({tag, "_fv_low"},   128'(frame_valid), 128'd0);
    chk({tag, "_keep_f"},   128'(FILTER),      exp_filter());
    chk({tag, "_keep_d"},   DATA,              exp_data());
  endtask

  initial begin
    int cyc;
    int first_fv;

    for (int k = 0; k < 9; k++)  mf[k] = 8'h00;
    for (int k = 0; k < 16; k++) md[k] = 8'h00;

    // ---- Test 1: reset values, full load, start-to-frame_valid latency ----
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    tick();
    chk("rst_state",  128'(state),       128'd0);
    chk("rst_filter", 128'(FILTER),      128'd0);
    chk("rst_data",   DATA,              128'd0);
    chk("rst_fv",     128'(frame_valid), 128'd0);
    chk("rst_rdy",    128'(in_ready),    128'd0);

    for (int k = 0; k < 9; k++)  nf[k] = 8'(k + 1);
    for (int k = 0; k < 16; k++) nd[k] = 8'(8'h10 + k);

    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    first_fv = -1;
    chk("t1_state_f", 128'(state), 128'd1);
    for (int i = 0; i < 25; i++) begin
      in_valid = 1'b1;
      in_byte  = (i < 9) ? nf[i] : nd[i-9];
      tick();
      cyc++;
      if (frame_valid && first_fv < 0) first_fv = cyc;
      if (i == 8) chk("t1_state_d", 128'(state), 128'd2);
    end
    in_valid = 1'b0;
    while (first_fv < 0 && cyc < 40) begin
      tick();
      cyc++;
      if (frame_valid) first_fv = cyc;
    end
    for (int k = 0; k < 9; k++)  mf[k] = nf[k];
    for (int k = 0; k < 16; k++) md[k] = nd[k];
    chk("t1_fv_latency", 128'(first_fv),  128'd26);
    chk("t1_state_h",    128'(state),     128'd3);
    chk("t1_filter",     128'(FILTER),    128'h090807060504030201);
    chk("t1_data",       DATA,            128'h1F1E1D1C1B1A19181716151413121110);
    chk("t1_rdy_hold",   128'(in_ready),  128'd0);
    handshake("t1");

    // ---- Test 2: filter reuse goes straight to LOAD_D ----
    for (int k = 0; k < 16; k++) nd[k] = 8'(8'h20 + k);
    load_frame("t2", 1'b1, 0, 1'b0);
    chk("t2_filter_kept", 128'(FILTER), 128'h090807060504030201);
    chk("t2_data",        DATA,         128'h2F2E2D2C2B2A29282726252423222120);
    handshake("t2");

    // ---- Test 3 + 6: alternating valid, start pulsed in LOAD_D and HOLD ----
    for (int k = 0; k < 9; k++)  nf[k] = 8'(k + 1);
    for (int k = 0; k < 16; k++) nd[k] = 8'(8'h10 + k);
    load_frame("t3", 1'b0, 1, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_stall_fv",    128'(frame_valid), 128'd1);
      chk("t3_stall_data",  DATA,              exp_data());
      chk("t3_stall_rdy",   128'(in_ready),    128'd0);
      chk("t3_stall_state", 128'(state),       128'd3);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    start       = 1'b0;
    chk("t6_hs_idle", 128'(state), 128'd0);
    tick();
    chk("t6_stay_idle", 128'(state), 128'd0);

    // ---- Test 4: abort after 5 data bytes, with a valid beat on that cycle ----
    randomize_frame();
    start = 1'b1;
    reuse_filter = 1'b1;
    tick();
    start = 1'b0;
    reuse_filter = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_byte(nd[k], pick_gap(2));
      md[k] = nd[k];
    end
    abort    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    #1;
    chk("t4_rdy_abort", 128'(in_ready), 128'd0);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("t4_state", 128'(state),       128'd0);
    chk("t4_data",  DATA,              exp_data());
    chk("t4_filt",  128'(FILTER),      exp_filter());
    repeat (3) begin
      tick();
      chk("t4_fv_low", 128'(frame_valid), 128'd0);
    end
    randomize_frame();
    load_frame("t4_next", 1'b0, 2, 1'b0);
    handshake("t4_next");

    // ---- Test 5: asynchronous reset in the middle of LOAD_D ----
    randomize_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) send_byte(nf[k], 0);
    for (int k = 0; k < 3; k++) send_byte(nd[k], 0);
    chk("t5_pre_state", 128'(state), 128'd2);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 9; k++)  mf[k] = 8'h00;
    for (int k = 0; k < 16; k++) md[k] = 8'h00;
    chk("t5_state",  128'(state),       128'd0);
    chk("t5_data",   DATA,              128'd0);
    chk("t5_filter", 128'(FILTER),      128'd0);
    chk("t5_fv",     128'(frame_valid), 128'd0);
    chk("t5_rdy",    128'(in_ready),    128'd0);
    tick();
    #2 rst = 1'b0;
    tick();

    // Reuse with no filter ever loaded since reset: FILTER stays zero.
    randomize_frame();
    load_frame("t5_reuse", 1'b1, 2, 1'b0);
    chk("t5_reuse_zero_f", 128'(FILTER), 128'd0);
    handshake("t5_reuse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
